connect_box_w16_t10_const: RTL and testbench

CONNECT_BOX_W16_T10_CONST -- requirements
Module: connect_box_w16_t10_const

---
 rtl/connect_box_w16_t10_const.sv | 85 ++++++++
 tb/tb_connect_box_w16_t10_const.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/connect_box_w16_t10_const.sv
// Connection box: one output driven by a configurable choice among the
// present track inputs, a programmable constant, or zero.
// The select code numbers only the tracks that exist, so position 5
// (which has no port) can never be chosen.
module connect_box_w16_t10_const #(
    parameter int                     WIDTH               = 16,
    parameter int                     NUM_TRACKS          = 10,
    parameter logic [NUM_TRACKS-1:0]  FEEDTHROUGH_OUTPUTS = 10'b1111101111,
    parameter int                     DEFAULT_SELECT      = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       config_addr,
    input  logic [31:0]       config_data,
    input  logic              config_en,
    input  logic [WIDTH-1:0]  in_0,
    input  logic [WIDTH-1:0]  in_1,
    input  logic [WIDTH-1:0]  in_2,
    input  logic [WIDTH-1:0]  in_3,
    input  logic [WIDTH-1:0]  in_4,
    input  logic [WIDTH-1:0]  in_6,
    input  logic [WIDTH-1:0]  in_7,
    input  logic [WIDTH-1:0]  in_8,
    input  logic [WIDTH-1:0]  in_9,
    output logic [WIDTH-1:0]  out
);

    localparam logic [7:0]       SEL_INDEX   = 8'h00;
    localparam logic [7:0]       CVAL_INDEX  = 8'h01;
    localparam logic [WIDTH-1:0] CVAL_RESET  = WIDTH'(7);

    logic [3:0]       sel;
    logic [WIDTH-1:0] cval;
    logic [WIDTH-1:0] track [NUM_TRACKS];
    int               present_code;
    logic             unused_cfg_bits;

    // Only the register index byte and the low data bits are meaningful
    assign unused_cfg_bits = ^{config_addr[23:0], config_data[31:16]};

    // Gather the inputs by physical position; the absent slot is tied off
    assign track[0] = in_0;
    assign track[1] = in_1;
    assign track[2] = in_2;
    assign track[3] = in_3;
    assign track[4] = in_4;
    assign track[5] = '0;
    assign track[6] = in_6;
    assign track[7] = in_7;
    assign track[8] = in_8;
    assign track[9] = in_9;

    // Configuration registers: reset wins over any simultaneous write
    always_ff @(posedge clk) begin
        if (reset) begin
            sel  <= 4'(DEFAULT_SELECT);
            cval <= CVAL_RESET;
        end else if (config_en) begin
            if (config_addr[31:24] == SEL_INDEX) begin
                sel <= config_data[3:0];
            end else if (config_addr[31:24] == CVAL_INDEX) begin
                cval <= config_data[WIDTH-1:0];
            end
        end
    end

    // Combinational mux: walk positions left to right, numbering present ones;
    // the code just past the last present input selects the constant
    always_comb begin
        out          = '0;
        present_code = 0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            if (FEEDTHROUGH_OUTPUTS[NUM_TRACKS-1-i]) begin
                if (present_code == int'(sel)) begin
                    out = track[i];
                end
                present_code = present_code + 1;
            end
        end
        if (present_code == int'(sel)) begin
            out = cval;
        end
    end

endmodule

// File: tb/tb_connect_box_w16_t10_const.sv
// Directed bench for the connection box: hand-computed expectations for
// reset state, compressed select decoding, constant and zero codes,
// ignored addresses, hold behaviour and reset priority.
module tb_connect_box_w16_t10_const;

    logic        clk;
    logic        reset;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_en;
    logic [15:0] in_0, in_1, in_2, in_3, in_4, in_6, in_7, in_8, in_9;
    logic [15:0] out;

    int check_count;
    int error_count;

    connect_box_w16_t10_const dut (
        .clk         (clk),
        .reset       (reset),
        .config_addr (config_addr),
        .config_data (config_data),
        .config_en   (config_en),
        .in_0        (in_0),
        .in_1        (in_1),
        .in_2        (in_2),
        .in_3        (in_3),
        .in_4        (in_4),
        .in_6        (in_6),
        .in_7        (in_7),
        .in_8        (in_8),
        .in_9        (in_9),
        .out         (out)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one configuration cycle across a single rising edge, then idle
    task automatic applyStimulus(input logic rst, input logic en,
                                 input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        reset       = rst;
        config_en   = en;
        config_addr = addr;
        config_data = data;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        config_en = 1'b0;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        reset       = 1'b0;
        config_en   = 1'b0;
        config_addr = '0;
        config_data = '0;
        in_0 = 16'h1000; in_1 = 16'h1001; in_2 = 16'h1002; in_3 = 16'h1003;
        in_4 = 16'h1004; in_6 = 16'h1006; in_7 = 16'h1007; in_8 = 16'h1008;
        in_9 = 16'h1009;

        // Reset selects in_8
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        checkOutput("reset_sel_in8", out, 16'h1008);
        in_8 = 16'h1234;
        #1;
        checkOutput("reset_in8_1234", out, 16'h1234);

        // sel=1 -> in_1, combinational follow
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h1);
        in_1 = 16'd4;
        #1;
        checkOutput("sel1_in1_4", out, 16'd4);
        in_1 = 16'd5;
        #1;
        checkOutput("sel1_in1_follow", out, 16'd5);

        // Compressed codes around the missing position
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h4);
        checkOutput("code4_in4", out, 16'h1004);
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h5);
        checkOutput("code5_in6", out, 16'h1006);
        // Upper data bits ignored: low nibble 6 -> in_7
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFF6);
        checkOutput("code6_hibits_in7", out, 16'h1007);
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h0);
        checkOutput("code0_in0", out, 16'h1000);

        // sel=8 -> in_9, then hold with config_en low
        in_9 = 16'd345;
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h8);
        checkOutput("sel8_in9", out, 16'd345);
        applyStimulus(1'b0, 1'b0, 32'h0000_0000, 32'h1);
        checkOutput("sel8_hold", out, 16'd345);

        // Constant code after reset, then reprogram constant
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h9);
        checkOutput("sel9_cval_reset", out, 16'd7);
        applyStimulus(1'b0, 1'b1, 32'h0100_0000, 32'h0000_BEEF);
        checkOutput("sel9_cval_beef", out, 16'hBEEF);

        // Low address bits ignored: index 0 with junk below -> sel=2
        applyStimulus(1'b0, 1'b1, 32'h0012_3456, 32'h2);
        checkOutput("addr_low_ignored", out, 16'h1002);

        // Zero codes and a write to an unknown index
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'd12);
        checkOutput("sel12_zero", out, 16'h0000);
        applyStimulus(1'b0, 1'b1, 32'h0500_0000, 32'h2);
        checkOutput("bad_index_noop", out, 16'h0000);
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'd10);
        checkOutput("sel10_zero", out, 16'h0000);
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'd15);
        checkOutput("sel15_zero", out, 16'h0000);

        // Reset beats a simultaneous write
        applyStimulus(1'b1, 1'b1, 32'h0000_0000, 32'h3);
        checkOutput("reset_wins", out, 16'h1234);
        // cval also back to 7
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h9);
        checkOutput("reset_cval7", out, 16'd7);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
